hcsr04_emulador: RTL and testbench

Synthesizable behavioural model of the HC-SR04 ultrasonic sensor. It is the responder side of the trigger/echo protocol that the sonar's sensor interface initiates. It accepts the trigger pulse, waits the sensor's burst delay, then drives an echo pulse whose width encodes a programmable distance. It is used on-board (loop-back to the sensor interface) and in simulation to exercise the measurement path without real hardware.

---
 rtl/hcsr04_emulador.sv | 178 +++++++++++++++++
 tb/tb_hcsr04_emulador.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hcsr04_emulador.sv
// HC-SR04 responder: accepts a trigger pulse, waits the burst delay, then drives an echo whose width encodes i_distancia.
// Optional macro EMULADOR_RUIDO_EN adds 0..255 LFSR cycles of jitter to valid echo pulses.
`timescale 1ns/1ps
module hcsr04_emulador #(
  parameter int CYCLES_PER_CM  = 2941,
  parameter int TRIG_MIN       = 500,
  parameter int DELAY_CYCLES   = 25000,
  parameter int TIMEOUT_CYCLES = 1900000,
  parameter int MAX_CM         = 400,
  parameter int RECOVER_CYCLES = 500000
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_trigger,
  input  logic [8:0] i_distancia,
  output logic       o_echo,
  output logic       o_ocupado,
  output logic       o_fora_alcance
);

  localparam int TW = $clog2(TRIG_MIN + 1);
  localparam logic [TW-1:0] L_TRIG_MIN    = TW'(TRIG_MIN);
  localparam logic [20:0]   L_DELAY_END   = 21'(DELAY_CYCLES - 1);
  localparam logic [20:0]   L_TIMEOUT_END = 21'(TIMEOUT_CYCLES - 1);
  localparam logic [20:0]   L_RECOVER_END = 21'(RECOVER_CYCLES - 1);
  localparam logic [11:0]   L_SUB_END     = 12'(CYCLES_PER_CM - 1);
  localparam logic [8:0]    L_MAX_CM      = 9'(MAX_CM);

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_BURST, S_ECHO, S_RECOVER} state_t;

  state_t          r_state;
  logic [TW-1:0]   r_trig_cnt;
  logic [8:0]      r_dist;
  logic            r_oor;
  logic [20:0]     r_cnt;
  logic [8:0]      r_cm;
  logic [11:0]     r_sub;
  logic            r_echo;
  logic            r_ocupado;
  logic            r_fora;

  logic            w_dist_oor;
  logic            w_cm_done;
  logic            w_timeout_done;

  assign w_dist_oor     = (i_distancia == 9'd0) || (i_distancia > L_MAX_CM);
  assign w_cm_done      = (r_sub == L_SUB_END) && (r_cm == r_dist - 9'd1);
  assign w_timeout_done = (r_cnt == L_TIMEOUT_END);

  assign o_echo         = r_echo;
  assign o_ocupado      = r_ocupado;
  assign o_fora_alcance = r_fora;

`ifdef EMULADOR_RUIDO_EN
  logic [7:0] r_lfsr;
  logic [7:0] r_noise;
  logic       r_tail;

  // x^8+x^6+x^5+x^4+1, free running from reset
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_lfsr <= 8'hA5;
    else            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_trig_cnt <= '0;
      r_dist     <= '0;
      r_oor      <= 1'b0;
      r_cnt      <= '0;
      r_cm       <= '0;
      r_sub      <= '0;
      r_echo     <= 1'b0;
      r_ocupado  <= 1'b0;
      r_fora     <= 1'b0;
`ifdef EMULADOR_RUIDO_EN
      r_noise    <= '0;
      r_tail     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_trigger) begin
            r_trig_cnt <= TW'(1);
            r_state    <= S_TRIG;
          end
        end
        S_TRIG: begin
          if (i_trigger) begin
            if (r_trig_cnt < L_TRIG_MIN) r_trig_cnt <= r_trig_cnt + TW'(1);
          end else if (r_trig_cnt >= L_TRIG_MIN) begin
            r_dist    <= i_distancia;
            r_oor     <= w_dist_oor;
            r_cnt     <= '0;
            r_ocupado <= 1'b1;
            r_state   <= S_BURST;
`ifdef EMULADOR_RUIDO_EN
            r_noise   <= r_lfsr;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BURST: begin
          if (r_cnt == L_DELAY_END) begin
            r_cnt   <= '0;
            r_sub   <= '0;
            r_cm    <= '0;
            r_echo  <= 1'b1;
            r_fora  <= r_oor;
            r_state <= S_ECHO;
`ifdef EMULADOR_RUIDO_EN
            r_tail  <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + 21'd1;
          end
        end
        S_ECHO: begin
          if (r_oor) begin
            if (w_timeout_done) begin
              r_echo  <= 1'b0;
              r_cnt   <= '0;
              r_state <= S_RECOVER;
            end else begin
              r_cnt <= r_cnt + 21'd1;
            end
          end
`ifdef EMULADOR_RUIDO_EN
          // jitter tail counts down the latched LFSR value after the cm loop
          else if (r_tail) begin
            if (r_cnt == 21'd0) begin
              r_echo  <= 1'b0;
              r_state <= S_RECOVER;
            end else begin
              r_cnt <= r_cnt - 21'd1;
            end
          end
`endif
          else if (w_cm_done) begin
`ifdef EMULADOR_RUIDO_EN
            if (r_noise == 8'd0) begin
              r_echo  <= 1'b0;
              r_cnt   <= '0;
              r_state <= S_RECOVER;
            end else begin
              r_tail <= 1'b1;
              r_cnt  <= {13'd0, r_noise} - 21'd1;
            end
`else
            r_echo  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RECOVER;
`endif
          end else if (r_sub == L_SUB_END) begin
            r_sub <= '0;
            r_cm  <= r_cm + 9'd1;
          end else begin
            r_sub <= r_sub + 12'd1;
          end
        end
        S_RECOVER: begin
          if (r_cnt == L_RECOVER_END) begin
            r_cnt     <= '0;
            r_ocupado <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 21'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hcsr04_emulador.sv
// Bench for hcsr04_emulador: timeline model of the trigger/echo protocol plus directed pulse-width checks.
`timescale 1ns/1ps
module tb_hcsr04_emulador;
  localparam int CPC  = 4;
  localparam int TMIN = 5;
  localparam int DLY  = 10;
  localparam int TMO  = 100;
  localparam int MAXC = 400;
  localparam int REC  = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trigger = 1'b0;
  logic [8:0] distancia = 9'd0;
  logic       echo, ocupado, fora;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hcsr04_emulador #(
    .CYCLES_PER_CM(CPC), .TRIG_MIN(TMIN), .DELAY_CYCLES(DLY),
    .TIMEOUT_CYCLES(TMO), .MAX_CM(MAXC), .RECOVER_CYCLES(REC)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_trigger(trigger), .i_distancia(distancia),
    .o_echo(echo), .o_ocupado(ocupado), .o_fora_alcance(fora)
  );

  function automatic void check(input string name, input int act_v, input int exp_v);
    n_vec++;
    if (act_v != exp_v) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d", name, act_v, exp_v);
    end
  endfunction

  // Timeline model: once a trigger is accepted at edge e_t, every output is a time window.
  int   cyc, run, e_t, rise_t, fall_t, bend_t;
  bit   act, m_oor, m_fora;
  logic [7:0] m_lfsr, m_lfsr_old;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; run = 0; act = 0; m_oor = 0; m_fora = 0;
      e_t = 0; rise_t = 0; fall_t = 0; bend_t = 0;
      m_lfsr = 8'hA5;
    end else begin
      int n;
      cyc++;
      m_lfsr_old = m_lfsr;
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      if (act && cyc <= bend_t) run = 0;
      else if (trigger) run++;
      else begin
        if (run >= TMIN) begin
          m_oor = (distancia == 0) || (distancia > MAXC);
          n = m_oor ? TMO : int'(distancia) * CPC;
`ifdef EMULADOR_RUIDO_EN
          if (!m_oor) n += int'(m_lfsr_old);
`endif
          act = 1; e_t = cyc; rise_t = cyc + DLY; fall_t = rise_t + n; bend_t = fall_t + REC;
        end
        run = 0;
      end
      if (act && cyc == rise_t) m_fora = m_oor;
    end
  end

  always @(negedge clk) begin
    int exp_v;
    exp_v = {29'd0, act && cyc >= rise_t && cyc < fall_t,
             act && cyc >= e_t && cyc < bend_t, m_fora};
    check($sformatf("cycle %0d echo/ocupado/fora", cyc), int'({29'd0, echo, ocupado, fora}), exp_v);
  end

  task automatic pulse(input logic [8:0] d, input int hi);
    @(negedge clk);
    distancia = d;
    trigger = 1'b1;
    repeat (hi) @(negedge clk);
    trigger = 1'b0;
  endtask

  // Samples n cycles after the trigger falls; optionally injects a second trigger mid-window.
  task automatic window(input int n, input int inj_at, input int inj_len, input logic [8:0] inj_d,
                        output int rise_d, output int width, output int busy);
    rise_d = -1; width = 0; busy = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (echo) begin
        width++;
        if (rise_d < 0) rise_d = k - 1;
      end
      if (ocupado) busy++;
      if (k == inj_at) begin trigger = 1'b1; distancia = inj_d; end
      if (k == inj_at + inj_len) trigger = 1'b0;
    end
  endtask

  task automatic check_valid(input string name, input int w, input int b, input int n);
`ifdef EMULADOR_RUIDO_EN
    check({name, " width in range"}, int'(w >= n && w <= n + 255), 1);
    check({name, " busy"}, b, DLY + w + REC);
`else
    check({name, " width"}, w, n);
    check({name, " busy"}, b, DLY + n + REC);
`endif
  endtask

  initial begin
    int rd, w, b;
    #1;
    check("reset echo", int'(echo), 0);
    check("reset ocupado", int'(ocupado), 0);
    check("reset fora", int'(fora), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    pulse(9'd7, 5);
    window(70, -1, 0, 9'd0, rd, w, b);
    check("d7 rise delay", rd, 10);
    check_valid("d7", w, b, 28);
    check("d7 fora", int'(fora), 0);

    pulse(9'd7, 4);
    window(20, -1, 0, 9'd0, rd, w, b);
    check("runt echo cycles", w, 0);
    check("runt ocupado cycles", b, 0);

    pulse(9'd1, 5);
    window(40, -1, 0, 9'd0, rd, w, b);
    check("d1 rise delay", rd, 10);
    check_valid("d1", w, b, 4);

    pulse(9'd0, 5);
    window(140, -1, 0, 9'd0, rd, w, b);
    check("d0 width", w, 100);
    check("d0 busy", b, 130);
    check("d0 fora", int'(fora), 1);

    pulse(9'd401, 5);
    window(140, -1, 0, 9'd0, rd, w, b);
    check("d401 width", w, 100);
    check("d401 fora", int'(fora), 1);

    pulse(9'd400, 5);
    window(1640, -1, 0, 9'd0, rd, w, b);
    check("d400 rise delay", rd, 10);
    check_valid("d400", w, b, 1600);
    check("d400 fora cleared", int'(fora), 0);

    pulse(9'd7, 5);
    window(90, 20, 6, 9'd50, rd, w, b);
    check_valid("retrigger d7", w, b, 28);

    pulse(9'd7, 5);
    repeat (15) @(negedge clk);
    check("pre-reset echo", int'(echo), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset echo", int'(echo), 0);
    check("async reset ocupado", int'(ocupado), 0);
    check("async reset fora", int'(fora), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    pulse(9'd7, 5);
    window(70, -1, 0, 9'd0, rd, w, b);
    check("post-reset rise delay", rd, 10);
    check_valid("post-reset d7", w, b, 28);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
